poly_actor_enable_invoke: RTL



---
 rtl/poly_actor_enable_invoke.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/poly_actor_enable_invoke.sv
// Parent controller of the polynomial-evaluation actor: fetches a command through FSM2,
// checks the dataflow enable condition for it, invokes it and waits with a watchdog.
module poly_actor_enable_invoke #(
  parameter int word_size      = 16,
  parameter int timeout_cycles = 4096,
  parameter int rst_hold       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_in,
  input  logic [word_size-1:0] pop_in_fifo_data,
  input  logic [word_size-1:0] pop_in_fifo_command,
  input  logic [word_size-1:0] free_out_result,
  input  logic [word_size-1:0] free_out_status,
  input  logic [7:0]           instr,
  input  logic [4:0]           arg2,
  input  logic                 done_fsm2,
  output logic                 start_fsm2,
  output logic [1:0]           next_instr,
  output logic                 busy,
  output logic [15:0]          fire_count,
  output logic                 err_instr,
  output logic                 timeout
);

  typedef enum logic [3:0] {
    IDLE, EN_SETUP, INV_SETUP, WAIT_SETUP, EN_INSTR, INV_INSTR, WAIT_INSTR, RST_WAIT, HALT
  } state_t;

  localparam logic [7:0] OP_STP = 8'd0;
  localparam logic [7:0] OP_EVP = 8'd1;
  localparam logic [7:0] OP_EVB = 8'd2;
  localparam logic [7:0] OP_RST = 8'd3;

  localparam int CNT_MAX = (timeout_cycles > rst_hold) ? timeout_cycles : rst_hold;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(timeout_cycles - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((rst_hold > 0) ? rst_hold - 1 : 0);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           instr_q, instr_d;
  logic [4:0]           arg2_q, arg2_d;
  logic                 start_q, start_d;
  logic [1:0]           next_instr_q, next_instr_d;
  logic                 busy_q, busy_d;
  logic [15:0]          fire_count_q, fire_count_d;
  logic                 err_instr_q, err_instr_d;
  logic                 timeout_q, timeout_d;

  logic                 fire_inc;
  logic                 err_hit;
  logic                 wd_expire;
  logic [word_size:0]   arg2_ext;
  logic [word_size:0]   data_need;
  logic [word_size:0]   slot_need;
  logic [word_size:0]   space_avail;
  logic                 instr_ready;

  // Requirements are formed one bit wider than the counts so arg2+1 never wraps.
  assign arg2_ext    = {{(word_size - 4){1'b0}}, arg2_q};
  assign space_avail = (free_out_result < free_out_status) ? {1'b0, free_out_result}
                                                           : {1'b0, free_out_status};

  always_comb begin
    data_need = '0;
    slot_need = '0;
    case (instr_q)
      OP_STP: begin
        data_need = arg2_ext + 1'b1;
        slot_need = (word_size + 1)'(1);
      end
      OP_EVP: begin
        data_need = (word_size + 1)'(1);
        slot_need = (word_size + 1)'(1);
      end
      OP_EVB: begin
        data_need = arg2_ext;
        slot_need = arg2_ext;
      end
      default: begin
        data_need = '0;
        slot_need = '0;
      end
    endcase
  end

  assign instr_ready = ({1'b0, pop_in_fifo_data} >= data_need) && (space_avail >= slot_need);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      instr_q      <= '0;
      arg2_q       <= '0;
      start_q      <= 1'b0;
      next_instr_q <= 2'b00;
      busy_q       <= 1'b0;
      fire_count_q <= '0;
      err_instr_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      instr_q      <= instr_d;
      arg2_q       <= arg2_d;
      start_q      <= start_d;
      next_instr_q <= next_instr_d;
      busy_q       <= busy_d;
      fire_count_q <= fire_count_d;
      err_instr_q  <= err_instr_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic; cnt_d defaults to zero so entering any wait state clears it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    instr_d   = instr_q;
    arg2_d    = arg2_q;
    fire_inc  = 1'b0;
    err_hit   = 1'b0;
    wd_expire = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_in) state_d = EN_SETUP;
      end
      EN_SETUP: begin
        if (!enable_in)                          state_d = IDLE;
        else if (pop_in_fifo_command != '0)      state_d = INV_SETUP;
      end
      INV_SETUP: state_d = WAIT_SETUP;
      WAIT_SETUP: begin
        if (done_fsm2) begin
          instr_d = instr;
          arg2_d  = arg2;
          err_hit = (instr > OP_RST);
          state_d = EN_INSTR;
        end else if (cnt_q == WD_LAST) begin
          wd_expire = 1'b1;
          state_d   = HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EN_INSTR: begin
        if (instr_q > OP_RST) state_d = EN_SETUP;
        else if (instr_ready) state_d = INV_INSTR;
      end
      INV_INSTR: state_d = (instr_q == OP_RST) ? RST_WAIT : WAIT_INSTR;
      WAIT_INSTR: begin
        if (done_fsm2) begin
          fire_inc = 1'b1;
          state_d  = EN_SETUP;
        end else if (cnt_q == WD_LAST) begin
          wd_expire = 1'b1;
          state_d   = HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RST_WAIT: begin
        // RST produces no done, so the firing completes after a fixed hold.
        if (cnt_q >= HOLD_LAST) begin
          fire_inc = 1'b1;
          state_d  = EN_SETUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: every output is registered from the upcoming state.
  always_comb begin
    start_d      = (state_d == INV_SETUP) || (state_d == INV_INSTR);
    next_instr_d = next_instr_q;
    if (state_d == INV_SETUP)      next_instr_d = 2'b00;
    else if (state_d == INV_INSTR) next_instr_d = 2'b01;
    busy_d       = (state_d != IDLE) && (state_d != HALT);
    fire_count_d = fire_inc ? fire_count_q + 16'd1 : fire_count_q;
    err_instr_d  = err_hit;
    timeout_d    = timeout_q | wd_expire;
  end

  assign start_fsm2 = start_q;
  assign next_instr = next_instr_q;
  assign busy       = busy_q;
  assign fire_count = fire_count_q;
  assign err_instr  = err_instr_q;
  assign timeout    = timeout_q;

endmodule
